sdram_patch_fetch: RTL

- Wishbone classic read master that gathers one 3x3 image patch from SDRAM for the convolution engine.
- Sits directly upstream of the conv core, on the same SDRAM Wishbone port the core's bench models.
- On start, it fetches 9 words row-major from a base address with row stride IMG_W and packs their low 16 bits into a 144-bit patch bus.
- It then holds the patch under a valid/ready handshake.

---
 rtl/sdram_patch_fetch.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_patch_fetch.sv
// Wishbone classic read master that gathers one 3x3 patch (9 words, row stride IMG_W)
// and presents the low 16 bits of each word on a 144-bit bus under valid/ready.
module sdram_patch_fetch #(
    parameter int IMG_W       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  base_addr,
    output logic         busy,
    output logic [143:0] PATCHES,
    output logic         patch_valid,
    input  logic         patch_ready,
    output logic         err,
    input  logic [31:0]  data_o,
    input  logic         stall_o,
    input  logic         sdram_ack,
    output logic         cyc_i,
    output logic         stb_i,
    output logic         we_i,
    output logic [3:0]   sel_i,
    output logic [31:0]  addr_i,
    output logic [31:0]  data_i
);

    localparam int              TW     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0]   TLIM   = TW'(ACK_TIMEOUT - 1);
    localparam logic [31:0]     STRIDE = 32'(IMG_W);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_ACK = 3'd2,
        GAP      = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t         state_r, state_s;
    logic [3:0]     k_r, k_s;
    logic [1:0]     col_r, col_s;
    logic [31:0]    row_base_r, row_base_s;
    logic [31:0]    addr_r, addr_s;
    logic [TW-1:0]  tcnt_r, tcnt_s;
    logic           cyc_r, cyc_s;
    logic           stb_r, stb_s;
    logic [3:0]     sel_r, sel_s;
    logic           busy_r, busy_s;
    logic           valid_r, valid_s;
    logic           err_r, err_s;
    logic [143:0]   patches_r, patches_s;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s    = state_r;
        k_s        = k_r;
        col_s      = col_r;
        row_base_s = row_base_r;
        addr_s     = addr_r;
        tcnt_s     = tcnt_r;
        cyc_s      = cyc_r;
        stb_s      = stb_r;
        busy_s     = busy_r;
        valid_s    = valid_r;
        err_s      = err_r;
        patches_s  = patches_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    row_base_s = base_addr;
                    col_s      = 2'd0;
                    k_s        = 4'd0;
                    addr_s     = base_addr;
                    err_s      = 1'b0;
                    busy_s     = 1'b1;
                    cyc_s      = 1'b1;
                    stb_s      = 1'b1;
                    tcnt_s     = '0;
                    state_s    = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ, WAIT_ACK: begin
                if (sdram_ack) begin
                    for (int i = 0; i < 9; i++) begin
                        patches_s[16*i +: 16] = (k_r == 4'(i)) ? data_o[15:0] : patches_r[16*i +: 16];
                    end
                    cyc_s   = 1'b0;
                    stb_s   = 1'b0;
                    state_s = GAP;
                end else if (tcnt_r == TLIM) begin
                    // Abort: captured elements stay, but the patch is never flagged valid.
                    cyc_s   = 1'b0;
                    stb_s   = 1'b0;
                    err_s   = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    tcnt_s  = tcnt_r + TW'(1);
                    state_s = (state_r == REQ && !stall_o) ? WAIT_ACK : state_r;
                end
            end
            GAP: begin
                if (k_r == 4'd8) begin
                    valid_s = 1'b1;
                    state_s = HOLD;
                end else begin
                    k_s = k_r + 4'd1;
                    if (col_r == 2'd2) begin
                        col_s      = 2'd0;
                        row_base_s = row_base_r + STRIDE;
                    end else begin
                        col_s = col_r + 2'd1;
                    end
                    addr_s  = row_base_s + {30'd0, col_s};
                    cyc_s   = 1'b1;
                    stb_s   = 1'b1;
                    tcnt_s  = '0;
                    state_s = REQ;
                end
            end
            HOLD: begin
                if (patch_ready) begin
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                cyc_s   = 1'b0;
                stb_s   = 1'b0;
                state_s = IDLE;
            end
        endcase

        sel_s = stb_s ? 4'b0011 : 4'b0000;
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            k_r        <= 4'd0;
            col_r      <= 2'd0;
            row_base_r <= 32'd0;
            addr_r     <= 32'd0;
            tcnt_r     <= '0;
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            sel_r      <= 4'b0000;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            patches_r  <= 144'd0;
        end else begin
            state_r    <= state_s;
            k_r        <= k_s;
            col_r      <= col_s;
            row_base_r <= row_base_s;
            addr_r     <= addr_s;
            tcnt_r     <= tcnt_s;
            cyc_r      <= cyc_s;
            stb_r      <= stb_s;
            sel_r      <= sel_s;
            busy_r     <= busy_s;
            valid_r    <= valid_s;
            err_r      <= err_s;
            patches_r  <= patches_s;
        end
    end

    assign busy        = busy_r;
    assign PATCHES     = patches_r;
    assign patch_valid = valid_r;
    assign err         = err_r;
    assign cyc_i       = cyc_r;
    assign stb_i       = stb_r;
    assign we_i        = 1'b0;
    assign sel_i       = sel_r;
    assign addr_i      = addr_r;
    assign data_i      = 32'd0;

endmodule
